calc_ring_queue: RTL and testbench

- Parametrised operand queue for the stream calculator.
- Circular buffer with configurable width and depth.
- Integrated ALU, so results are computed internally instead of being supplied on `in`.
- Multi-cycle shift-add multiplier with a ready handshake.
- Sticky error flag plus an error code, clearable without reset.
- Sits between the command decoder and the display/output stage.

---
 rtl/calc_ring_queue.sv | 207 ++++++++++++++++++++
 tb/tb_calc_ring_queue.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/calc_ring_queue.sv
// Operand queue for the stream calculator: a ring buffer with an integrated ALU,
// a bit-serial shift-add multiplier and a sticky error flag.
module calc_ring_queue #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         apply,
  input  logic [3:0]                   op,
  input  logic [W-1:0]                 in,
  input  logic                         clr_err,
  output logic                         ready,
  output logic [W-1:0]                 first,
  output logic [W-1:0]                 second,
  output logic [W-1:0]                 tail,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty,
  output logic                         full,
  output logic                         valid,
  output logic [2:0]                   err_code
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SW = CW + 1;
  localparam int MW = $clog2(W+1);

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_MUL  = 4'd4,
    OP_PUSH = 4'd5,
    OP_POP  = 4'd6,
    OP_DUP  = 4'd7,
    OP_CLR  = 4'd8
  } op_t;

  typedef enum logic {S_IDLE, S_MUL} state_t;

  logic [W-1:0]  mem [DEPTH];
  logic [IW-1:0] head;
  state_t        state;

  logic [W-1:0]  mul_a, mul_b, mul_acc, product;
  logic [MW-1:0] mul_cnt;

  logic [IW-1:0] idx1, idx2, app_idx, tail_idx;
  logic          accept, cmd_err;
  logic [2:0]    cmd_code;
  logic [W-1:0]  alu_res;
  logic          mem_we;
  logic [W-1:0]  mem_wdata;

  // Sums never reach 2*DEPTH, so one conditional subtract is a full modulo.
  function automatic logic [IW-1:0] wrap(input logic [SW-1:0] x);
    logic [SW-1:0] r;
    r = (x >= SW'(DEPTH)) ? x - SW'(DEPTH) : x;
    return IW'(r);
  endfunction

  always_comb begin
    idx1     = wrap(SW'(head) + SW'(1));
    idx2     = wrap(SW'(head) + SW'(2));
    app_idx  = wrap(SW'(head) + SW'(count));
    tail_idx = (count == '0) ? head : wrap(SW'(head) + SW'(count) - SW'(1));
  end

  always_comb begin
    accept   = apply && ready;
    cmd_err  = 1'b0;
    cmd_code = 3'd0;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_MUL: begin
        if (count < CW'(2)) begin cmd_err = 1'b1; cmd_code = 3'd1; end
      end
      OP_PUSH: begin
        if (count == CW'(DEPTH)) begin cmd_err = 1'b1; cmd_code = 3'd2; end
      end
      OP_POP: begin
        if (count == '0) begin cmd_err = 1'b1; cmd_code = 3'd1; end
      end
      OP_DUP: begin
        if (count == '0) begin
          cmd_err = 1'b1; cmd_code = 3'd1;
        end else if (count == CW'(DEPTH)) begin
          cmd_err = 1'b1; cmd_code = 3'd2;
        end
      end
      OP_CLR: ;
      default: begin cmd_err = 1'b1; cmd_code = 3'd3; end
    endcase
  end

  always_comb begin
    case (op)
      OP_ADD:  alu_res = first + second;
      OP_SUB:  alu_res = first - second;
      OP_AND:  alu_res = first & second;
      default: alu_res = first | second;
    endcase
    product = mul_acc + (mul_b[0] ? mul_a : '0);
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_wdata = '0;
    if (!rst) begin
      if (state == S_MUL) begin
        if (mul_cnt == MW'(W-1)) begin
          mem_we    = 1'b1;
          mem_wdata = product;
        end
      end else if (accept && !cmd_err) begin
        case (op)
          OP_ADD, OP_SUB, OP_AND, OP_OR: begin mem_we = 1'b1; mem_wdata = alu_res; end
          OP_PUSH: begin mem_we = 1'b1; mem_wdata = in; end
          OP_DUP:  begin mem_we = 1'b1; mem_wdata = mem[head]; end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[app_idx] <= mem_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head     <= '0;
      count    <= '0;
      state    <= S_IDLE;
      ready    <= 1'b1;
      valid    <= 1'b1;
      err_code <= '0;
      mul_a    <= '0;
      mul_b    <= '0;
      mul_acc  <= '0;
      mul_cnt  <= '0;
    end else begin
      // A new error on the same edge as clr_err overrides the clear.
      if (accept && cmd_err) begin
        valid <= 1'b0;
        if (valid || clr_err) err_code <= cmd_code;
      end else if (clr_err) begin
        valid    <= 1'b1;
        err_code <= '0;
      end

      case (state)
        S_IDLE: begin
          if (accept && !cmd_err) begin
            case (op)
              OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                head  <= idx2;
                count <= count - CW'(1);
              end
              OP_MUL: begin
                mul_a   <= first;
                mul_b   <= second;
                mul_acc <= '0;
                mul_cnt <= '0;
                state   <= S_MUL;
                ready   <= 1'b0;
              end
              OP_PUSH, OP_DUP: count <= count + CW'(1);
              OP_POP: begin
                head  <= idx1;
                count <= count - CW'(1);
              end
              OP_CLR: begin
                head  <= '0;
                count <= '0;
              end
              default: ;
            endcase
          end
        end
        S_MUL: begin
          mul_acc <= product;
          mul_a   <= mul_a << 1;
          mul_b   <= mul_b >> 1;
          mul_cnt <= mul_cnt + MW'(1);
          if (mul_cnt == MW'(W-1)) begin
            head  <= idx2;
            count <= count - CW'(1);
            state <= S_IDLE;
            ready <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    empty  = (count == '0);
    full   = (count == CW'(DEPTH));
    first  = (count >= CW'(1)) ? mem[head]     : '0;
    second = (count >= CW'(2)) ? mem[idx1]     : '0;
    tail   = (count >= CW'(1)) ? mem[tail_idx] : '0;
  end

endmodule

// File: tb/tb_calc_ring_queue.sv
// Directed bench for calc_ring_queue (W=8, DEPTH=4) with hand-computed expectations.
module tb_calc_ring_queue;
  logic       clk = 1'b0;
  logic       rst, apply, clr_err;
  logic [3:0] op;
  logic [7:0] in;
  logic       ready, empty, full, valid;
  logic [7:0] first, second, tail;
  logic [2:0] count;
  logic [2:0] err_code;

  int checks = 0;
  int errors = 0;

  calc_ring_queue #(.W(8), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .apply(apply), .op(op), .in(in), .clr_err(clr_err),
    .ready(ready), .first(first), .second(second), .tail(tail), .count(count),
    .empty(empty), .full(full), .valid(valid), .err_code(err_code)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; apply = 1'b0; clr_err = 1'b0; op = '0; in = '0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic cmd3(input logic [3:0] o, input logic [7:0] v, input logic ce);
    @(negedge clk);
    apply = 1'b1; op = o; in = v; clr_err = ce;
    @(posedge clk); #1;
    apply = 1'b0; clr_err = 1'b0;
  endtask

  task automatic cmd(input logic [3:0] o, input logic [7:0] v);
    cmd3(o, v, 1'b0);
  endtask

  initial begin
    rst = 1'b1; apply = 1'b0; clr_err = 1'b0; op = '0; in = '0;
    do_reset();
    chk("rst_ready", ready, 1);
    chk("rst_valid", valid, 1);
    chk("rst_err", err_code, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_count", count, 0);
    chk("rst_first", first, 0);
    chk("rst_second", second, 0);
    chk("rst_tail", tail, 0);

    // 1: basic add
    cmd(5, 3);  chk("t1_ready_a", ready, 1);
    cmd(5, 5);  chk("t1_ready_b", ready, 1);
    chk("t1_second", second, 5);
    cmd(0, 0);  chk("t1_ready_c", ready, 1);
    chk("t1_count", count, 1);
    chk("t1_first", first, 8);
    chk("t1_tail", tail, 8);
    chk("t1_valid", valid, 1);

    // 2: multiply with ignored apply during busy
    do_reset();
    cmd(5, 200);
    cmd(5, 100);
    cmd(4, 0);
    chk("t2_ready0", ready, 0);
    chk("t2_count0", count, 2);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 3) begin apply = 1'b1; op = 4'd5; in = 8'd77; end
      @(posedge clk); #1;
      apply = 1'b0;
      if (i < 8) begin
        chk("t2_busy_ready", ready, 0);
        chk("t2_busy_count", count, 2);
      end
    end
    chk("t2_ready_done", ready, 1);
    chk("t2_first", first, 32);
    chk("t2_tail", tail, 32);
    chk("t2_count", count, 1);
    chk("t2_valid", valid, 1);

    // 3: overflow and clear
    do_reset();
    cmd(5, 1); cmd(5, 2); cmd(5, 3); cmd(5, 4);
    chk("t3_full", full, 1);
    cmd(5, 9);
    chk("t3_valid", valid, 0);
    chk("t3_err", err_code, 2);
    chk("t3_tail", tail, 4);
    chk("t3_count", count, 4);
    @(negedge clk); clr_err = 1'b1;
    @(posedge clk); #1; clr_err = 1'b0;
    chk("t3_clr_valid", valid, 1);
    chk("t3_clr_err", err_code, 0);

    // 4: wrap-around
    do_reset();
    cmd(5, 1); cmd(5, 2); cmd(5, 3); cmd(5, 4);
    cmd(6, 0); cmd(6, 0);
    cmd(5, 5); cmd(5, 6);
    chk("t4_first", first, 3);
    chk("t4_second", second, 4);
    chk("t4_tail", tail, 6);
    chk("t4_count", count, 4);
    chk("t4_full", full, 1);
    cmd(7, 0);
    chk("t4_dup_err", err_code, 2);
    chk("t4_dup_count", count, 4);

    // 5: sticky first error
    do_reset();
    cmd(5, 7);
    cmd(0, 0);
    chk("t5_err", err_code, 1);
    chk("t5_count", count, 1);
    chk("t5_first", first, 7);
    cmd(12, 0);
    chk("t5_sticky", err_code, 1);
    chk("t5_valid", valid, 0);
    cmd3(12, 0, 1'b1);
    chk("t5_clr_new", err_code, 3);
    chk("t5_clr_valid", valid, 0);

    // 6: reset during multiply
    do_reset();
    cmd(5, 3); cmd(5, 4);
    cmd(4, 0);
    @(posedge clk); @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    chk("t6_count", count, 0);
    chk("t6_empty", empty, 1);
    chk("t6_ready", ready, 1);
    chk("t6_valid", valid, 1);
    chk("t6_err", err_code, 0);
    chk("t6_first", first, 0);
    repeat (10) @(posedge clk);
    #1;
    chk("t6_no_append", count, 0);

    // 7: sub/and/or, dup, clr, pop underflow
    do_reset();
    cmd(5, 5); cmd(5, 9);
    cmd(1, 0);   chk("t7_sub", first, 252);
    cmd(5, 8'hF0);
    cmd(2, 0);   chk("t7_and", first, 8'hF0);
    cmd(5, 8'h0F);
    cmd(3, 0);   chk("t7_or", first, 8'hFF);
    cmd(7, 0);   chk("t7_dup_tail", tail, 8'hFF);
    chk("t7_dup_count", count, 2);
    cmd(8, 0);   chk("t7_clr_empty", empty, 1);
    chk("t7_clr_valid", valid, 1);
    cmd(6, 0);   chk("t7_pop_err", err_code, 1);
    chk("t7_pop_valid", valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
